// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : Round-robin arbiter sharing one lower memory port among
//            N_CLIENTS requesters, with a watchdog abort for stalled
//            transactions.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int N_CLIENTS = 4,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int TIMEOUT   = 1024
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [N_CLIENTS-1:0]                req_read,
    input  logic [N_CLIENTS-1:0]                req_write,
    input  logic [N_CLIENTS*ADDR_W-1:0]         req_addr,
    input  logic [N_CLIENTS*DATA_W-1:0]         req_data,
    input  logic [N_CLIENTS*(DATA_W/8)-1:0]     req_data_en,
    output logic [N_CLIENTS-1:0]                client_hit,
    output logic [N_CLIENTS-1:0]                client_done,
    output logic [N_CLIENTS-1:0]                client_err,
    output logic [DATA_W-1:0]                   client_data_o,
    output logic [ADDR_W-1:0]                   lower_addr,
    output logic [DATA_W-1:0]                   lower_data_i,
    output logic [DATA_W/8-1:0]                 lower_data_en,
    output logic                                lower_read_en,
    output logic                                lower_write_en,
    input  logic                                lower_hit,
    input  logic                                lower_done,
    input  logic [DATA_W-1:0]                   lower_data_o,
    output logic                                busy,
    output logic [$clog2(N_CLIENTS)-1:0]        grant_id
);

    localparam int c_id_w = $clog2(N_CLIENTS);
    localparam int c_be_w = DATA_W / 8;
    localparam int c_wd_w = $clog2(TIMEOUT);
    localparam logic [c_wd_w-1:0]    c_wd_last = c_wd_w'(TIMEOUT - 1);
    localparam logic [N_CLIENTS-1:0] c_one     = N_CLIENTS'(1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t                 r_state;
    logic [c_id_w-1:0]      r_ptr;
    logic [c_id_w-1:0]      r_grant;
    logic [c_wd_w-1:0]      r_wd;
    logic [N_CLIENTS-1:0]   r_hit;
    logic [N_CLIENTS-1:0]   r_done;
    logic [N_CLIENTS-1:0]   r_err;
    logic [DATA_W-1:0]      r_cdata;
    logic [ADDR_W-1:0]      r_laddr;
    logic [DATA_W-1:0]      r_ldata;
    logic [c_be_w-1:0]      r_lbe;
    logic                   r_lrd;
    logic                   r_lwr;

    logic [N_CLIENTS-1:0]   w_req;
    logic                   w_any;
    logic [c_id_w-1:0]      w_winner;
    logic [c_id_w-1:0]      w_next_ptr;

    function automatic logic [c_id_w-1:0] f_wrap(input int v);
        f_wrap = c_id_w'(v % N_CLIENTS);
    endfunction

    assign w_req      = req_read | req_write;
    assign w_next_ptr = f_wrap(int'(r_grant) + 1);

    // Scan downward so the last hit kept is the first requester at or after r_ptr.
    always_comb begin
        w_any    = 1'b0;
        w_winner = '0;
        for (int k = N_CLIENTS - 1; k >= 0; k--) begin
            if (w_req[f_wrap(int'(r_ptr) + k)]) begin
                w_any    = 1'b1;
                w_winner = f_wrap(int'(r_ptr) + k);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_grant <= '0;
            r_wd    <= '0;
            r_hit   <= '0;
            r_done  <= '0;
            r_err   <= '0;
            r_cdata <= '0;
            r_laddr <= '0;
            r_ldata <= '0;
            r_lbe   <= '0;
            r_lrd   <= 1'b0;
            r_lwr   <= 1'b0;
        end else begin
            r_hit  <= '0;
            r_done <= '0;
            r_err  <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_grant <= w_winner;
                        r_laddr <= req_addr[int'(w_winner)*ADDR_W +: ADDR_W];
                        r_ldata <= req_data[int'(w_winner)*DATA_W +: DATA_W];
                        r_lbe   <= req_data_en[int'(w_winner)*c_be_w +: c_be_w];
                        r_lwr   <= req_write[w_winner];
                        r_lrd   <= !req_write[w_winner] && req_read[w_winner];
                        r_hit   <= c_one << w_winner;
                        r_wd    <= '0;
                        r_state <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    // Completion takes priority over both accept and watchdog.
                    if (lower_done) begin
                        r_lrd   <= 1'b0;
                        r_lwr   <= 1'b0;
                        r_done  <= c_one << r_grant;
                        r_cdata <= lower_data_o;
                        r_ptr   <= w_next_ptr;
                        r_state <= S_IDLE;
                    end else if (r_wd == c_wd_last) begin
                        r_lrd   <= 1'b0;
                        r_lwr   <= 1'b0;
                        r_done  <= c_one << r_grant;
                        r_err   <= c_one << r_grant;
                        r_cdata <= '0;
                        r_ptr   <= w_next_ptr;
                        r_state <= S_IDLE;
                    end else begin
                        r_wd <= r_wd + 1'b1;
                        if (lower_hit) begin
                            r_lrd <= 1'b0;
                            r_lwr <= 1'b0;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign client_hit     = r_hit;
    assign client_done    = r_done;
    assign client_err     = r_err;
    assign client_data_o  = r_cdata;
    assign lower_addr     = r_laddr;
    assign lower_data_i   = r_ldata;
    assign lower_data_en  = r_lbe;
    assign lower_read_en  = r_lrd;
    assign lower_write_en = r_lwr;
    assign busy           = (r_state == S_BUSY);
    assign grant_id       = r_grant;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Brief    : Self-checking bench for mem_port_arbiter against a
//            transaction-level round-robin reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;
    localparam int TO = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic [N-1:0]      req_read, req_write;
    logic [N*AW-1:0]   req_addr;
    logic [N*DW-1:0]   req_data;
    logic [N*BW-1:0]   req_data_en;
    logic [N-1:0]      client_hit, client_done, client_err;
    logic [DW-1:0]     client_data_o;
    logic [AW-1:0]     lower_addr;
    logic [DW-1:0]     lower_data_i;
    logic [BW-1:0]     lower_data_en;
    logic              lower_read_en, lower_write_en;
    logic              lower_hit, lower_done;
    logic [DW-1:0]     lower_data_o;
    logic              busy;
    logic [1:0]        grant_id;

    mem_port_arbiter #(
        .N_CLIENTS(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .reset(reset),
        .req_read(req_read), .req_write(req_write),
        .req_addr(req_addr), .req_data(req_data), .req_data_en(req_data_en),
        .client_hit(client_hit), .client_done(client_done), .client_err(client_err),
        .client_data_o(client_data_o),
        .lower_addr(lower_addr), .lower_data_i(lower_data_i), .lower_data_en(lower_data_en),
        .lower_read_en(lower_read_en), .lower_write_en(lower_write_en),
        .lower_hit(lower_hit), .lower_done(lower_done), .lower_data_o(lower_data_o),
        .busy(busy), .grant_id(grant_id)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    int m_ptr    = 0;

    logic [N-1:0]  rd_v, wr_v;
    logic [AW-1:0] a_v [N];
    logic [DW-1:0] d_v [N];
    logic [BW-1:0] e_v [N];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_client(input int i);
        a_v[i] = $urandom;
        d_v[i] = $urandom;
        e_v[i] = BW'($urandom_range(0, 15));
    endtask

    task automatic drive_reqs();
        req_read  = rd_v;
        req_write = wr_v;
        for (int i = 0; i < N; i++) begin
            req_addr[i*AW +: AW]    = a_v[i];
            req_data[i*DW +: DW]    = d_v[i];
            req_data_en[i*BW +: BW] = e_v[i];
        end
    endtask

    // Round-robin rule: first requester at m_ptr, m_ptr+1, ... modulo N.
    function automatic int pick_winner();
        for (int k = 0; k < N; k++) begin
            if (rd_v[(m_ptr + k) % N] || wr_v[(m_ptr + k) % N])
                return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},  busy, 0);
        check({tag, "_gid"},   grant_id, 0);
        check({tag, "_hit"},   client_hit, 0);
        check({tag, "_done"},  client_done, 0);
        check({tag, "_err"},   client_err, 0);
        check({tag, "_cdata"}, client_data_o, 0);
        check({tag, "_laddr"}, lower_addr, 0);
        check({tag, "_ldata"}, lower_data_i, 0);
        check({tag, "_lbe"},   lower_data_en, 0);
        check({tag, "_lrd"},   lower_read_en, 0);
        check({tag, "_lwr"},   lower_write_en, 0);
    endtask

    // lat < 0: lower memory never completes, watchdog must abort.
    task automatic do_txn(input int lat, input int hit_at, input bit hit_same,
                          input bit drop, input logic [DW-1:0] rdata);
        int w;
        bit is_wr, is_rd, en_on;
        int n_wait;
        drive_reqs();
        w = pick_winner();
        tick();
        if (w < 0) begin
            check("idle_busy", busy, 0);
            check("idle_hit", client_hit, 0);
            return;
        end
        is_wr = wr_v[w];
        is_rd = !is_wr && rd_v[w];
        check("grant_busy", busy, 1);
        check("grant_hit",  client_hit, N'(1) << w);
        check("grant_id",   grant_id, w);
        check("grant_addr", lower_addr, a_v[w]);
        check("grant_data", lower_data_i, d_v[w]);
        check("grant_be",   lower_data_en, e_v[w]);
        check("grant_wr",   lower_write_en, is_wr);
        check("grant_rd",   lower_read_en, is_rd);
        check("grant_done", client_done, 0);
        if (drop) begin
            rd_v[w] = 1'b0;
            wr_v[w] = 1'b0;
        end
        drive_reqs();
        en_on  = 1'b1;
        n_wait = (lat < 0) ? TO - 1 : lat;
        for (int k = 0; k < n_wait; k++) begin
            lower_hit = (k == hit_at);
            tick();
            if (lower_hit) en_on = 1'b0;
            lower_hit = 1'b0;
            check("wait_busy", busy, 1);
            check("wait_hit",  client_hit, 0);
            check("wait_done", client_done, 0);
            check("wait_rd",   lower_read_en, en_on & is_rd);
            check("wait_wr",   lower_write_en, en_on & is_wr);
        end
        if (lat < 0) begin
            tick();
            check("wd_done",  client_done, N'(1) << w);
            check("wd_err",   client_err, N'(1) << w);
            check("wd_cdata", client_data_o, 0);
        end else begin
            lower_done   = 1'b1;
            lower_hit    = hit_same;
            lower_data_o = rdata;
            tick();
            lower_done = 1'b0;
            lower_hit  = 1'b0;
            check("cpl_done",  client_done, N'(1) << w);
            check("cpl_err",   client_err, 0);
            check("cpl_cdata", client_data_o, rdata);
        end
        check("cpl_busy", busy, 0);
        check("cpl_hit",  client_hit, 0);
        check("cpl_rd",   lower_read_en, 0);
        check("cpl_wr",   lower_write_en, 0);
        check("cpl_gid",  grant_id, w);
        m_ptr = (w + 1) % N;
    endtask

    initial begin
        reset        = 1'b1;
        lower_hit    = 1'b0;
        lower_done   = 1'b0;
        lower_data_o = '0;
        rd_v = '0;
        wr_v = '0;
        for (int i = 0; i < N; i++) rand_client(i);
        drive_reqs();
        #12;
        check_all_zero("rst");
        @(negedge clk);
        reset = 1'b0;

        // Completion strobes while idle must be ignored.
        lower_done = 1'b1;
        lower_hit  = 1'b1;
        tick();
        lower_done = 1'b0;
        lower_hit  = 1'b0;
        check("idle_cpl_done", client_done, 0);
        check("idle_cpl_busy", busy, 0);

        // Single read from client 2.
        rd_v = 4'b0100;
        a_v[2] = 32'h100;
        do_txn(3, -1, 1'b0, 1'b1, 32'hDEADBEEF);

        // Byte-enabled write from client 1, accepted one cycle into BUSY.
        wr_v = 4'b0010;
        d_v[1] = 32'h12345678;
        e_v[1] = 4'b0011;
        do_txn(3, 0, 1'b0, 1'b1, $urandom);

        // Hit and done together; then done with no hit at all.
        rd_v = 4'b1000;
        do_txn(1, -1, 1'b1, 1'b1, $urandom);
        wr_v = 4'b0001;
        do_txn(2, -1, 1'b0, 1'b1, $urandom);

        // All clients hold requests: rotation starting from current pointer.
        rd_v = 4'hF;
        for (int t = 0; t < 5; t++) do_txn(1, 0, 1'b0, 1'b0, $urandom);
        rd_v = '0;
        wr_v = '0;
        do_txn(0, -1, 1'b0, 1'b1, '0);

        // Watchdog abort, another client waiting behind it.
        rd_v = 4'b1010;
        do_txn(-1, 2, 1'b0, 1'b1, '0);
        do_txn(0, -1, 1'b0, 1'b1, $urandom);

        // Randomized traffic.
        for (int t = 0; t < 30; t++) begin
            for (int i = 0; i < N; i++) rand_client(i);
            rd_v = rd_v | N'($urandom_range(0, 15));
            wr_v = wr_v | (N'($urandom_range(0, 15)) & N'($urandom_range(0, 15)));
            if ($urandom_range(0, 7) == 0)
                do_txn(-1, $urandom_range(0, 9), 1'b0, 1'b1, '0);
            else
                do_txn($urandom_range(0, 5), $urandom_range(0, 5),
                       1'($urandom_range(0, 1)), 1'b1, $urandom);
        end
        rd_v = '0;
        wr_v = '0;
        drive_reqs();
        tick();
        tick();

        // Asynchronous reset between edges while BUSY.
        rd_v = 4'b0100;
        wr_v = '0;
        drive_reqs();
        tick();
        check("pre_rst_busy", busy, 1);
        #2;
        reset = 1'b1;
        #1;
        check_all_zero("async_rst");
        @(negedge clk);
        reset = 1'b0;
        m_ptr = 0;
        rd_v  = 4'b0101;
        do_txn(2, 0, 1'b0, 1'b1, $urandom);
        do_txn(1, -1, 1'b0, 1'b1, $urandom);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
